// File: rtl/ins_fetch.sv
// Instruction fetch stage: fetch PC, in-order request/response tracking, a small
// buffer feeding decode, and redirect handling that drops stale in-flight responses.
module ins_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] IR,
    output logic [31:0] ir_pc
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fpc_q, fpc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [31:0]     buf_data_q [FIFO_DEPTH];
    logic [31:0]     buf_data_d [FIFO_DEPTH];
    logic [31:0]     buf_pc_q   [FIFO_DEPTH];
    logic [31:0]     buf_pc_d   [FIFO_DEPTH];
    logic [31:0]     ir_q, ir_d;
    logic [31:0]     ir_pc_q, ir_pc_d;

    logic [CW:0]     occ_s;
    logic            gnt_s;
    logic            rsp_s;
    logic            push_s;
    logic            pop_s;
    logic [31:0]     rpc_s;

    assign occ_s     = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req  = (state_q != BOOT) && !redirect_valid && (occ_s < DEPTH_W);
    assign imem_addr = fpc_q;
    assign gnt_s     = imem_req && imem_gnt;
    // A response with nothing outstanding is ignored so the counter cannot wrap.
    assign rsp_s     = imem_rvalid && (outstanding_q != {CW{1'b0}});
    assign rpc_s     = redirect_pc & 32'hFFFF_FFFC;
    assign ir_valid  = (count_q != {CW{1'b0}});
    assign IR        = ir_q;
    assign ir_pc     = ir_pc_q;

    // Next-state: counters, buffer, PCs, FSM and the registered decode-facing head.
    always_comb begin
        state_d       = state_q;
        fpc_d         = fpc_q;
        rsp_pc_d      = rsp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        head_d        = head_q;
        tail_d        = tail_q;
        buf_data_d    = buf_data_q;
        buf_pc_d      = buf_pc_q;
        push_s        = 1'b0;
        pop_s         = 1'b0;

        if (redirect_valid) begin
            fpc_d         = rpc_s;
            rsp_pc_d      = rpc_s;
            count_d       = {CW{1'b0}};
            head_d        = {PW{1'b0}};
            tail_d        = {PW{1'b0}};
            outstanding_d = outstanding_q - {{PW{1'b0}}, rsp_s};
            discard_d     = outstanding_q - {{PW{1'b0}}, rsp_s};
        end else begin
            if (gnt_s) begin
                fpc_d = fpc_q + 32'd4;
            end else begin
                fpc_d = fpc_q;
            end
            outstanding_d = outstanding_q + {{PW{1'b0}}, gnt_s} - {{PW{1'b0}}, rsp_s};
            if (rsp_s && (discard_q != {CW{1'b0}})) begin
                discard_d = discard_q - {{PW{1'b0}}, 1'b1};
            end else begin
                push_s = rsp_s;
            end
            pop_s = ir_valid && ir_ready;
            if (push_s) begin
                buf_data_d[tail_q] = imem_rdata;
                buf_pc_d[tail_q]   = rsp_pc_q;
                tail_d             = tail_q + 1'b1;
                rsp_pc_d           = rsp_pc_q + 32'd4;
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + 1'b1;
            end else begin
                head_d = head_q;
            end
            count_d = count_q + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
        end

        case (state_q)
            BOOT:    state_d = RUN;
            RUN,
            FLUSH:   state_d = (discard_d != {CW{1'b0}}) ? FLUSH : RUN;
            default: state_d = BOOT;
        endcase

        ir_d    = buf_data_d[head_d];
        ir_pc_d = buf_pc_d[head_d];
    end

    // State, counter and buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            fpc_q         <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            count_q       <= {CW{1'b0}};
            outstanding_q <= {CW{1'b0}};
            discard_q     <= {CW{1'b0}};
            head_q        <= {PW{1'b0}};
            tail_q        <= {PW{1'b0}};
            ir_q          <= 32'h0000_0000;
            ir_pc_q       <= 32'h0000_0000;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_data_q[i] <= 32'h0000_0000;
                buf_pc_q[i]   <= 32'h0000_0000;
            end
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            rsp_pc_q      <= rsp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            buf_data_q    <= buf_data_d;
            buf_pc_q      <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: small in-order memory model with a response hold
// control, hand-derived expectations for reset, streaming, backpressure and redirects.
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [31:0] IR;
    logic [31:0] ir_pc;

    int          n_total = 0;
    int          n_bad = 0;
    logic        gnt_en = 1'b1;
    logic        hold = 1'b0;
    logic [31:0] pend [$];

    ins_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .IR(IR), .ir_pc(ir_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'h0002_8393 + (a << 8);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // One clock: memory drives its response, grant is sampled, edge, model updates.
    task automatic cyc();
        logic        g;
        logic [31:0] ga;
        if (!hold && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memw(pend[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        imem_gnt = gnt_en;
        #1;
        g  = imem_req && imem_gnt;
        ga = imem_addr;
        @(posedge clk);
        if (imem_rvalid) void'(pend.pop_front());
        if (g) pend.push_back(ga);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pend.delete();
        redirect_valid = 1'b0;
        ir_ready = 1'b0;
        hold = 1'b0;
        gnt_en = 1'b1;
        imem_rvalid = 1'b0;
        imem_gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic get_word(input string tag, input logic [31:0] pc);
        int n = 0;
        while (!ir_valid && n < 8) begin
            cyc();
            n++;
        end
        chk({tag, "_valid"}, {31'h0, ir_valid}, 32'h1);
        chk({tag, "_pc"}, ir_pc, pc);
        chk({tag, "_ir"}, IR, memw(pc));
        cyc();
    endtask

    task automatic run_t1(input string p);
        do_reset();
        ir_ready = 1'b1;
        chk({p, "_rst_req"}, {31'h0, imem_req}, 32'h0);
        chk({p, "_rst_addr"}, imem_addr, 32'h0);
        chk({p, "_rst_valid"}, {31'h0, ir_valid}, 32'h0);
        chk({p, "_rst_ir"}, IR, 32'h0);
        chk({p, "_rst_pc"}, ir_pc, 32'h0);
        cyc();
        chk({p, "_c2_req"}, {31'h0, imem_req}, 32'h1);
        chk({p, "_c2_addr"}, imem_addr, 32'h0);
        cyc();
        cyc();
        chk({p, "_first_valid"}, {31'h0, ir_valid}, 32'h1);
        chk({p, "_first_ir"}, IR, 32'h0002_8393);
        chk({p, "_first_pc"}, ir_pc, 32'h0);
        cyc();
        get_word({p, "_w4"}, 32'h4);
        get_word({p, "_w8"}, 32'h8);
    endtask

    initial begin
        // Test 1: basic streaming.
        run_t1("t1");

        // Test 2: decode stalls, buffer fills, single pop.
        do_reset();
        repeat (4) cyc();
        chk("t2_valid", {31'h0, ir_valid}, 32'h1);
        chk("t2_pc0", ir_pc, 32'h0);
        chk("t2_full_req", {31'h0, imem_req}, 32'h0);
        cyc();
        cyc();
        chk("t2_hold_ir", IR, memw(32'h0));
        chk("t2_hold_pc", ir_pc, 32'h0);
        chk("t2_hold_req", {31'h0, imem_req}, 32'h0);
        ir_ready = 1'b1;
        cyc();
        ir_ready = 1'b0;
        chk("t2_pop_pc", ir_pc, 32'h4);
        chk("t2_pop_ir", IR, memw(32'h4));
        chk("t2_new_req", {31'h0, imem_req}, 32'h1);
        chk("t2_new_addr", imem_addr, 32'h8);
        cyc();
        chk("t2_after_req", {31'h0, imem_req}, 32'h0);

        // Test 3: redirect with two requests in flight.
        do_reset();
        ir_ready = 1'b1;
        hold = 1'b1;
        repeat (3) cyc();
        chk("t3_inflight_req", {31'h0, imem_req}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        cyc();
        redirect_valid = 1'b0;
        hold = 1'b0;
        chk("t3_state", 32'(dut.state_q), 32'h2);
        chk("t3_discard", 32'(dut.discard_q), 32'h2);
        cyc();
        chk("t3_drop1_valid", {31'h0, ir_valid}, 32'h0);
        chk("t3_req", {31'h0, imem_req}, 32'h1);
        chk("t3_addr", imem_addr, 32'h100);
        cyc();
        chk("t3_drop2_valid", {31'h0, ir_valid}, 32'h0);
        cyc();
        chk("t3_new_valid", {31'h0, ir_valid}, 32'h1);
        chk("t3_new_pc", ir_pc, 32'h100);
        chk("t3_new_ir", IR, memw(32'h100));

        // Test 4: redirect coinciding with a response and a pending pop.
        do_reset();
        ir_ready = 1'b1;
        hold = 1'b1;
        repeat (3) cyc();
        hold = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("t4_state_flush", 32'(dut.state_q), 32'h2);
        chk("t4_discard", 32'(dut.discard_q), 32'h1);
        chk("t4_valid0", {31'h0, ir_valid}, 32'h0);
        chk("t4_req", {31'h0, imem_req}, 32'h1);
        chk("t4_addr", imem_addr, 32'h200);
        cyc();
        chk("t4_state_run", 32'(dut.state_q), 32'h1);
        chk("t4_valid1", {31'h0, ir_valid}, 32'h0);
        cyc();
        chk("t4_new_valid", {31'h0, ir_valid}, 32'h1);
        chk("t4_new_pc", ir_pc, 32'h200);
        chk("t4_new_ir", IR, memw(32'h200));

        // Test 5: grant withheld for three cycles.
        do_reset();
        ir_ready = 1'b1;
        gnt_en = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("t5_req", {31'h0, imem_req}, 32'h1);
            chk("t5_addr", imem_addr, 32'h0);
            cyc();
        end
        chk("t5_fpc", dut.fpc_q, 32'h0);
        gnt_en = 1'b1;
        get_word("t5_w0", 32'h0);

        // Test 6: asynchronous reset mid-stream, then full restart.
        do_reset();
        ir_ready = 1'b1;
        repeat (4) cyc();
        chk("t6_pre_valid", {31'h0, ir_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'h0, ir_valid}, 32'h0);
        chk("t6_async_req", {31'h0, imem_req}, 32'h0);
        chk("t6_async_addr", imem_addr, 32'h0);
        run_t1("t6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
